// File: rtl/dram_rmw_ctrl.sv
// dram_rmw_ctrl: single-outstanding request controller in front of a
// single-port synchronous RAM. Reads pass through. Full-word writes go
// straight to the RAM. Partial-byte writes become a read-modify-write.
// Writes with no byte enables complete without touching the RAM.
//
// Ports
//   clk, aresetn         clock (rising edge), async active-low reset
//   i_req_*/o_req_ready  request channel: valid/ready, wen, addr, be, data
//   o_rsp_*/i_rsp_ready  response channel: valid/ready, data (read word or
//                        final written word)
//   o_ram_*              RAM enable, write enable, word address, write data
//   i_ram_data           RAM read data, valid the cycle after a read access
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request
// READ   | RAM read access in progress (read or partial write)
// WAIT   | RAM data returns; capture read word or merge new bytes into it
// WRITE  | RAM write access of the merged word
// RESP   | response valid, held until the consumer takes it
//
// Every output is a flop. Each output flop is loaded with the value that
// belongs to the state being entered, so outputs line up with the state
// and no input reaches an output combinationally.

module dram_rmw_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [BE_W-1:0]   i_req_be,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_ram_en,
    output logic              o_ram_wen,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    input  logic [DATA_W-1:0] i_ram_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t              state_q;
    logic                wen_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic [DATA_W-1:0]   merge_d;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                ram_en_q;
    logic                ram_wen_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;

    // Enabled bytes come from the request, the rest from the old RAM word.
    always_comb begin
        merge_d = wdata_q;
        for (int k = 0; k < BE_W; k++) begin
            if (!be_q[k]) begin
                merge_d[8*k +: 8] = i_ram_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            wen_q       <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ram_en_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            // RAM strobes are single-cycle pulses; only READ/WRITE entry raises them.
            ram_en_q  <= 1'b0;
            ram_wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wen_q       <= i_req_wen;
                        be_q        <= i_req_be;
                        wdata_q     <= i_req_data;
                        ram_addr_q  <= i_req_addr;
                        if (i_req_wen && (&i_req_be)) begin
                            merge_q    <= i_req_data;
                            ram_data_q <= i_req_data;
                            ram_en_q   <= 1'b1;
                            ram_wen_q  <= 1'b1;
                            state_q    <= S_WRITE;
                        end else if (i_req_wen && (i_req_be == '0)) begin
                            rsp_data_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            ram_en_q <= 1'b1;
                            state_q  <= S_READ;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!wen_q) begin
                        rsp_data_q  <= i_ram_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        merge_q    <= merge_d;
                        ram_data_q <= merge_d;
                        ram_en_q   <= 1'b1;
                        ram_wen_q  <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    rsp_data_q  <= merge_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_ram_en    = ram_en_q;
    assign o_ram_wen   = ram_wen_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_data  = ram_data_q;

endmodule
